// File: rtl/cmp_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
// Contents:
//   cmp_state_t     - controller states (IDLE, RUN)
//   cmp_result_t    - encoded compare outcome
//   cmp_flags_t     - one-hot {lt, eq, gt} flag bundle used for cascade and result
//   resolve_cascade - priority resolution of the cascade inputs (eq > gt > lt, none -> eq)
//   result_to_flags - expand an encoded result into one-hot flags
package cmp_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } cmp_state_t;

  typedef enum logic [1:0] {
    CMP_NONE,
    CMP_LT,
    CMP_EQ,
    CMP_GT
  } cmp_result_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  // Outcome when every digit matched: defer to the less-significant stage.
  function automatic cmp_result_t resolve_cascade(input cmp_flags_t cas);
    cmp_result_t res;
    if (cas.eq) begin
      res = CMP_EQ;
    end else if (cas.gt) begin
      res = CMP_GT;
    end else if (cas.lt) begin
      res = CMP_LT;
    end else begin
      res = CMP_EQ;
    end
    return res;
  endfunction

  function automatic cmp_flags_t result_to_flags(input cmp_result_t res);
    cmp_flags_t flags;
    flags = '0;
    case (res)
      CMP_LT:  flags.lt = 1'b1;
      CMP_EQ:  flags.eq = 1'b1;
      CMP_GT:  flags.gt = 1'b1;
      default: flags = '0;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational unsigned compare of one DIGIT-bit digit pair.
// Ports:
//   a_i, b_i   - digits to compare
//   lt_o       - a_i <  b_i
//   eq_o       - a_i == b_i
//   gt_o       - a_i >  b_i
module digit_comparator #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/seq_mag_comparator.sv
// Digit-serial magnitude comparator, MSB-first, DIGIT bits per cycle, with
// early exit on the first differing digit and cascade inputs for chaining.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   start                  - compare request, accepted only while idle
//   a, b                   - operands, captured on accept
//   signed_mode            - 1 = two's-complement compare, captured on accept
//   lt_in, eq_in, gt_in    - cascade from less-significant stage, captured on accept
//   busy                   - compare in progress
//   done                   - one-cycle pulse when the result becomes valid
//   lt_out, eq_out, gt_out - one-hot result, held until the next accept
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             lt_out,
  output logic             eq_out,
  output logic             gt_out
);

  localparam int unsigned N        = WIDTH / DIGIT;
  localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  cmp_state_t       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  cmp_flags_t       cas_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  cmp_flags_t       res_q;

  logic [DIGIT-1:0] dig_a_c;
  logic [DIGIT-1:0] dig_b_c;
  logic             dig_lt_c;
  logic             dig_eq_c;
  logic             dig_gt_c;
  cmp_flags_t       cas_flags_c;

  // Current digit sits at the top of the shift registers. Flipping the sign
  // bit of the leading digit turns a two's-complement compare into unsigned.
  always_comb begin
    dig_a_c = a_q[WIDTH-1 -: DIGIT];
    dig_b_c = b_q[WIDTH-1 -: DIGIT];
    if (signed_q && (idx_q == '0)) begin
      dig_a_c[DIGIT-1] = ~dig_a_c[DIGIT-1];
      dig_b_c[DIGIT-1] = ~dig_b_c[DIGIT-1];
    end
  end

  digit_comparator #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .a_i  (dig_a_c),
    .b_i  (dig_b_c),
    .lt_o (dig_lt_c),
    .eq_o (dig_eq_c),
    .gt_o (dig_gt_c)
  );

  assign cas_flags_c = result_to_flags(resolve_cascade(cas_q));

  // Controller: accept, walk digits MSB-first, exit at first difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      cas_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            cas_q    <= '{lt: lt_in, eq: eq_in, gt: gt_in};
            idx_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (!dig_eq_c) begin
            res_q   <= '{lt: dig_lt_c, eq: 1'b0, gt: dig_gt_c};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (idx_q == LAST_IDX) begin
            res_q   <= cas_flags_c;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            a_q   <= a_q << DIGIT;
            b_q   <= b_q << DIGIT;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign lt_out = res_q.lt;
  assign eq_out = res_q.eq;
  assign gt_out = res_q.gt;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator (WIDTH=8, DIGIT=2, N=4).
module tb_seq_mag_comparator;

  localparam int unsigned W = 8;
  localparam int unsigned D = 2;
  localparam int unsigned NDIG = W / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signed_mode;
  logic         lt_in;
  logic         eq_in;
  logic         gt_in;
  logic         busy;
  logic         done;
  logic         lt_out;
  logic         eq_out;
  logic         gt_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vs;
    logic         vl;
    logic         ve;
    logic         vg;
    logic [2:0]   eres;
    int           elat;
  } vec_t;

  vec_t vecs[12];

  seq_mag_comparator #(
    .WIDTH (W),
    .DIGIT (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .lt_in       (lt_in),
    .eq_in       (eq_in),
    .gt_in       (gt_in),
    .busy        (busy),
    .done        (done),
    .lt_out      (lt_out),
    .eq_out      (eq_out),
    .gt_out      (gt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] res_now();
    return {lt_out, eq_out, gt_out};
  endfunction

  // Whole-value reference: arithmetic compare plus first differing digit.
  function automatic void ref_model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                    input logic vs, input logic vl, input logic ve,
                                    input logic vg, output logic [2:0] eres,
                                    output int elat);
    logic [W-1:0] x;
    int pos;
    x = va ^ vb;
    pos = -1;
    for (int i = 0; i < int'(W); i++) if (x[i]) pos = i;
    if (pos < 0) begin
      elat = NDIG;
      eres = ve ? R_EQ : vg ? R_GT : vl ? R_LT : R_EQ;
    end else begin
      elat = ((int'(W) - 1 - pos) / int'(D)) + 1;
      if (vs) eres = ($signed(va) < $signed(vb)) ? R_LT : R_GT;
      else    eres = (va < vb) ? R_LT : R_GT;
    end
  endfunction

  task automatic do_cmp(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vs, input logic vl, input logic ve, input logic vg,
                        input logic [2:0] eres, input int elat);
    int   lat;
    logic got;
    @(negedge clk);
    a = va; b = vb; signed_mode = vs; lt_in = vl; eq_in = ve; gt_in = vg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    signed_mode = 1'($urandom); lt_in = 1'($urandom);
    eq_in = 1'($urandom); gt_in = 1'($urandom);
    check({nm, " busy@accept"}, 32'(busy), 32'(1));
    check({nm, " done@accept"}, 32'(done), 32'(0));
    check({nm, " cleared@accept"}, 32'(res_now()), 32'(0));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 16) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
      else check({nm, " busy while running"}, 32'(busy), 32'(1));
    end
    check({nm, " done seen"}, 32'(got), 32'(1));
    check({nm, " latency"}, 32'(lat), 32'(elat));
    check({nm, " result"}, 32'(res_now()), 32'(eres));
    check({nm, " busy@result"}, 32'(busy), 32'(0));
    @(posedge clk); #1;
    check({nm, " done one cycle"}, 32'(done), 32'(0));
    check({nm, " result held"}, 32'(res_now()), 32'(eres));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rl;
    logic         re;
    logic         rg;
    logic [2:0]   er;
    int           el;

    vecs[0]  = '{8'hC0, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, R_EQ, 4};
    vecs[1]  = '{8'h40, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, R_LT, 1};
    vecs[2]  = '{8'hF0, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, R_GT, 2};
    vecs[3]  = '{8'hF0, 8'h70, 1'b1, 1'b0, 1'b0, 1'b0, R_LT, 1};
    vecs[4]  = '{8'hF0, 8'h70, 1'b0, 1'b0, 1'b0, 1'b0, R_GT, 1};
    vecs[5]  = '{8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, R_GT, 4};
    vecs[6]  = '{8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, R_EQ, 4};
    vecs[7]  = '{8'h55, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, R_EQ, 4};
    vecs[8]  = '{8'h55, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, R_GT, 4};
    vecs[9]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, R_LT, 1};
    vecs[10] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, R_GT, 4};
    vecs[11] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, R_GT, 4};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset result", 32'(res_now()), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_cmp($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vs,
             vecs[i].vl, vecs[i].ve, vecs[i].vg, vecs[i].eres, vecs[i].elat);
    end

    // Start during RUN is ignored.
    @(negedge clk);
    a = 8'h55; b = 8'h55; signed_mode = 1'b0;
    lt_in = 1'b1; eq_in = 1'b0; gt_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;          // t0
    start = 1'b0;
    @(posedge clk); #1;          // t0+1
    check("ign busy t1", 32'(busy), 32'(1));
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'hFF; lt_in = 1'b0; gt_in = 1'b1;
    @(posedge clk); #1;          // t0+2
    start = 1'b0;
    check("ign busy t2", 32'(busy), 32'(1));
    check("ign done t2", 32'(done), 32'(0));
    @(posedge clk); #1;          // t0+3
    check("ign done t3", 32'(done), 32'(0));
    @(posedge clk); #1;          // t0+4
    check("ign done t4", 32'(done), 32'(1));
    check("ign result t4", 32'(res_now()), 32'(R_LT));
    check("ign busy t4", 32'(busy), 32'(0));
    @(posedge clk); #1;          // t0+5
    check("ign done t5", 32'(done), 32'(0));
    check("ign busy t5", 32'(busy), 32'(0));
    check("ign result t5", 32'(res_now()), 32'(R_LT));

    // Start held high: second compare accepted in the done cycle.
    @(negedge clk);
    a = 8'h40; b = 8'hC0; signed_mode = 1'b0;
    lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;          // t0
    a = 8'hF0; b = 8'hC0;
    @(posedge clk); #1;          // t0+1
    check("b2b done t1", 32'(done), 32'(1));
    check("b2b result t1", 32'(res_now()), 32'(R_LT));
    check("b2b busy t1", 32'(busy), 32'(0));
    @(posedge clk); #1;          // t0+2: second accept
    start = 1'b0;
    check("b2b busy t2", 32'(busy), 32'(1));
    check("b2b cleared t2", 32'(res_now()), 32'(0));
    check("b2b done t2", 32'(done), 32'(0));
    @(posedge clk); #1;          // t0+3
    check("b2b done t3", 32'(done), 32'(0));
    @(posedge clk); #1;          // t0+4
    check("b2b done t4", 32'(done), 32'(1));
    check("b2b result t4", 32'(res_now()), 32'(R_GT));

    // Reset mid-RUN, with start asserted alongside reset.
    @(negedge clk);
    a = 8'h01; b = 8'h00; signed_mode = 1'b0;
    lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;          // t0
    start = 1'b0;
    @(posedge clk); #1;          // t0+1
    check("rst done t1", 32'(done), 32'(0));
    @(posedge clk); #1;          // t0+2
    check("rst done t2", 32'(done), 32'(0));
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;          // t0+3
    check("rst busy t3", 32'(busy), 32'(0));
    check("rst done t3", 32'(done), 32'(0));
    check("rst result t3", 32'(res_now()), 32'(0));
    rst = 1'b0; start = 1'b0;
    do_cmp("restart", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, R_GT, 4);

    // Randomized against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      rs = 1'($urandom); rl = 1'($urandom); re = 1'($urandom); rg = 1'($urandom);
      ref_model(ra, rb, rs, rl, re, rg, er, el);
      do_cmp($sformatf("rnd%0d a=%0h b=%0h s=%0b", i, ra, rb, rs), ra, rb, rs, rl, re, rg, er, el);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Parametrised, digit-serial magnitude comparator with cascade inputs and a start/done handshake. It compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, and terminates early at the first differing digit. It supports unsigned and two's-complement modes. It is the multi-cycle successor to the 8-bit combinational cascadable comparator, for wide operands where a single-cycle WIDTH-bit compare is too costly.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; N = WIDTH/DIGIT digit steps.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- signed_mode  in  1  1 = two's-complement compare; sampled on accept.
- lt_in, eq_in, gt_in  in  1 each  cascade from less-significant stage; sampled on accept.
- busy  out  1  high while a compare is in progress.
- done  out  1  single-cycle pulse when the result becomes valid.
- lt_out, eq_out, gt_out  out  1 each  result, one-hot when valid; held until next accept.

## Operation
- States: IDLE, RUN. There is no separate DONE state; the result registers carry the outcome.
- IDLE, start=1: capture a, b, mode and cascade; clear lt/eq/gt_out to 0; digit index := 0; go RUN; busy := 1.
- RUN, digit i (i=0 is most significant):
  - Compare a_digit vs b_digit unsigned.
  - In signed mode, for i=0 only, invert the top bit of both digits before comparing.
- RUN, digits differ: set lt_out or gt_out, done := 1, busy := 0, go IDLE.
- RUN, digits equal, i < N-1: i := i+1.
- RUN, digits equal, i = N-1: resolve from captured cascade, done := 1, go IDLE. Cascade priority:
  - eq_in=1 → EQ.
  - Else gt_in=1 → GT.
  - Else lt_in=1 → LT.
  - Else (all 0) → EQ.
- start while busy=1: ignored, with no effect on the in-flight compare.
- start in the same cycle done pulses: accepted, because busy is already 0 in that cycle.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset values: busy=0, done=0, lt_out=0, eq_out=0, gt_out=0, state IDLE.
- Accept at edge t0. Digit i is evaluated between t0+i and t0+i+1.
- Result and done are registered at edge t0+1+k, where k is the index of the first differing digit (or k = N-1 if all digits are equal).
- Latency is 1 to N cycles. done is high for exactly one cycle.
- busy is high from t0 up to (not including) the result edge. The earliest next accept is at the result edge itself.
- rst mid-RUN: the next edge forces all reset values, the in-flight compare is discarded, and no done pulse is produced.
- rst and start in the same cycle: rst wins, and start is not accepted.

## Structure
- Package cmp_pkg:
  - cmp_state_t {IDLE, RUN}.
  - cmp_result_t {CMP_NONE, CMP_LT, CMP_EQ, CMP_GT}.
  - Cascade-resolution function.
- Sub-module digit_comparator: combinational, DIGIT-bit unsigned lt/eq/gt; instantiated once.
- Top level: operand shift registers (shift left by DIGIT per step) or an index mux, digit counter of width clog2(N), FSM, result registers.

## Test plan
All scenarios use WIDTH=8, DIGIT=2, so N=4.
- Unsigned, a=0xC0, b=0xC0, eq_in=1 → eq_out=1 with done at t0+4; busy high for 4 cycles.
- Unsigned, a=0x40, b=0xC0 → lt_out=1, done at t0+1 (early exit on digit 0).
- Unsigned, a=0xF0, b=0xC0 → gt_out=1, done at t0+2.
- a=0xF0, b=0x70:
  - signed_mode=1 → lt_out=1 at t0+1.
  - Repeated with signed_mode=0 → gt_out=1 at t0+1.
- a=b=0x55 with lt_in=1, eq_in=0, gt_in=0 → lt_out=1 at t0+4. A start pulse at t0+2 with a=0x00 is ignored, and the result is unchanged.
- Compare a=0x01, b=0x00 and assert rst at t0+2 → all outputs 0 at t0+3 with no done pulse. A start at t0+4 completes normally with gt_out=1 at t0+8.
